// File: rtl/seq_checker_pkg.sv
// Shared definitions for the sequence checker: FSM state encoding and
// the widths of the word and error counters.
package seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int WORD_CNT_W = 32;
    localparam int ERR_CNT_W  = 16;

endpackage

// File: rtl/seq_checker_if.sv
// Read-side handshake between the sequence checker and an upstream async FIFO.
// master = checker (issues reads), slave = FIFO (returns words).
interface seq_checker_if #(
    parameter int W = 12
);
    logic         r;
    logic         rok;
    logic [W-1:0] rd;

    modport master (output r, input rok, input rd);
    modport slave  (input r, output rok, output rd);
endinterface

// File: rtl/seq_watchdog.sv
// Idle-cycle watchdog: counts CHECK cycles without a consume and raises a
// sticky stall flag one cycle after the count reaches STALL_CYCLES.
module seq_watchdog #(
    parameter int STALL_CYCLES = 1024
) (
    input  logic rclk,
    input  logic rst,
    input  logic consume,
    input  logic active,
    output logic stall
);
    localparam int CW = $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_CYCLES);

    logic [CW-1:0] idle_cnt;

    // The counter parks at LIMIT so a long idle stretch cannot wrap it.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            if (consume) begin
                idle_cnt <= '0;
            end else if (active && (idle_cnt != LIMIT)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (idle_cnt == LIMIT) begin
                stall <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_checker.sv
// Incrementing-sequence checker on an async FIFO read port, with stall watchdog.
// Define SEQ_CHECKER_HALT_ON_FAIL_EN to stop reading at the first mismatch.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int W            = 12,
    parameter int STALL_CYCLES = 1024
) (
    input  logic                  rclk,
    input  logic                  rst,
    seq_checker_if.master         fifo,
    output logic                  fail,
    output logic                  stall,
    output logic [WORD_CNT_W-1:0] wordCount,
    output logic [ERR_CNT_W-1:0]  errCount,
    output logic [W-1:0]          expected
);
    // state  | meaning
    // IDLE   | post-reset, r low, one cycle before reading starts
    // SYNC   | r high, waiting for the first word to seed the sequence
    // CHECK  | r high, every consumed word compared against expected
    // HALT   | r low after a mismatch (halt-on-fail build only)

    state_t       state, state_nxt;
    logic [1:0]   rst_sync;
    logic         rst_int;
    logic         r_int;
    logic         consume;
    logic         mismatch;
    logic [W-1:0] rd_inc;

    // Assert asynchronously, release two rclk edges after rst drops.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end
    assign rst_int = rst_sync[1];

    assign fifo.r   = r_int;
    assign consume  = r_int & fifo.rok;
    assign mismatch = consume && (state == ST_CHECK) && (fifo.rd != expected);
    assign rd_inc   = fifo.rd + 1'b1;

    always_ff @(posedge rclk or posedge rst_int) begin
        if (rst_int) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_int     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                r_int = 1'b1;
                if (consume) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                r_int = 1'b1;
`ifdef SEQ_CHECKER_HALT_ON_FAIL_EN
                if (mismatch) begin
                    state_nxt = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
                r_int = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rst_int) begin
        if (rst_int) begin
            expected  <= '0;
            wordCount <= '0;
            errCount  <= '0;
            fail      <= 1'b0;
        end else if (consume) begin
            if (!(&wordCount)) begin
                wordCount <= wordCount + 1'b1;
            end
`ifdef SEQ_CHECKER_HALT_ON_FAIL_EN
            // Expected is frozen on the failing word so it shows what was missed.
            if (!mismatch) begin
                expected <= rd_inc;
            end
`else
            expected <= rd_inc;
`endif
            if (mismatch) begin
                fail <= 1'b1;
                if (!(&errCount)) begin
                    errCount <= errCount + 1'b1;
                end
            end
        end
    end

    seq_watchdog #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_watchdog (
        .rclk   (rclk),
        .rst    (rst_int),
        .consume(consume),
        .active (state == ST_CHECK),
        .stall  (stall)
    );
endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: a reference model pushes the expected
// post-consume outputs to a scoreboard queue, popped after each consume edge.
module tb_seq_checker;
    logic        rclk;
    logic        rst;
    logic        fail;
    logic        stall;
    logic [31:0] wordCount;
    logic [15:0] errCount;
    logic [11:0] expected;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] exp;
        logic [31:0] wc;
        logic [15:0] ec;
        logic        fail;
    } obs_t;

    obs_t sb[$];

    logic        m_synced;
    logic        m_halted;
    logic [11:0] m_exp;
    logic [31:0] m_wc;
    logic [15:0] m_ec;
    logic        m_fail;

    seq_checker_if #(.W(12)) fifo_if ();

    seq_checker #(
        .W           (12),
        .STALL_CYCLES(1024)
    ) dut (
        .rclk     (rclk),
        .rst      (rst),
        .fifo     (fifo_if),
        .fail     (fail),
        .stall    (stall),
        .wordCount(wordCount),
        .errCount (errCount),
        .expected (expected)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_consume(input logic [11:0] w);
        obs_t e;
        if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
        if (!m_synced) begin
            m_synced = 1'b1;
            m_exp    = w + 12'd1;
        end else if (w == m_exp) begin
            m_exp = w + 12'd1;
        end else begin
            m_fail = 1'b1;
            if (m_ec != 16'hFFFF) m_ec = m_ec + 1;
`ifdef SEQ_CHECKER_HALT_ON_FAIL_EN
            m_halted = 1'b1;
`else
            m_exp = w + 12'd1;
`endif
        end
        e.exp  = m_exp;
        e.wc   = m_wc;
        e.ec   = m_ec;
        e.fail = m_fail;
        sb.push_back(e);
    endtask

    task automatic feed(input logic [11:0] w);
        obs_t e;
        int   n;
        fifo_if.rok = 1'b1;
        fifo_if.rd  = w;
        if (m_halted) begin
            repeat (4) @(posedge rclk);
            #1;
            chk("halt_r_low", fifo_if.r, 0);
            chk("halt_wc_frozen", wordCount, m_wc);
            return;
        end
        n = 0;
        while (fifo_if.r !== 1'b1 && n < 16) begin
            @(posedge rclk);
            #1;
            n++;
        end
        chk("r_ready", fifo_if.r, 1);
        model_consume(w);
        @(posedge rclk);
        #1;
        e = sb.pop_front();
        chk("expected", expected, e.exp);
        chk("wordCount", wordCount, e.wc);
        chk("errCount", errCount, e.ec);
        chk("fail", fail, e.fail);
    endtask

    // Reset is asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        int n;
        rst = 1'b1;
        #1;
        chk("rst_r", fifo_if.r, 0);
        chk("rst_fail", fail, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wc", wordCount, 0);
        chk("rst_ec", errCount, 0);
        chk("rst_exp", expected, 0);
        m_synced = 1'b0;
        m_halted = 1'b0;
        m_exp    = '0;
        m_wc     = '0;
        m_ec     = '0;
        m_fail   = 1'b0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rst = 1'b0;
        n = 0;
        while (fifo_if.r !== 1'b1 && n < 10) begin
            @(posedge rclk);
            #1;
            n++;
        end
        chk("release_latency", n, 3);
        chk("release_no_consume", wordCount, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        fifo_if.rok = 1'b0;
        fifo_if.rd  = '0;
        #12;

        // Back-to-back ramp 0x000..0x1FF.
        do_reset();
        for (int i = 0; i < 512; i++) feed(12'(i));
        fifo_if.rok = 1'b0;
        chk("ramp_wc", wordCount, 512);
        chk("ramp_exp", expected, 12'h200);
        chk("ramp_ec", errCount, 0);
        chk("ramp_fail", fail, 0);

        // Wrap-around across 0xFFF -> 0x000.
        do_reset();
        feed(12'hFFD);
        feed(12'hFFE);
        feed(12'hFFF);
        feed(12'h000);
        feed(12'h001);
        fifo_if.rok = 1'b0;
        chk("wrap_exp", expected, 12'h002);
        chk("wrap_ec", errCount, 0);

        // Watchdog: 1024 idle CHECK cycles, stall on the next one, then sticky.
        do_reset();
        feed(12'h000);
        feed(12'h001);
        feed(12'h002);
        fifo_if.rok = 1'b0;
        repeat (1024) @(posedge rclk);
        #1;
        chk("stall_not_yet", stall, 0);
        @(posedge rclk);
        #1;
        chk("stall_set", stall, 1);
        feed(12'h003);
        fifo_if.rok = 1'b0;
        chk("stall_sticky", stall, 1);
        chk("stall_no_err", errCount, 0);

        // Mismatch: 5, 6, 9, 10.
        do_reset();
        feed(12'd5);
        feed(12'd6);
        feed(12'd9);
`ifdef SEQ_CHECKER_HALT_ON_FAIL_EN
        chk("halt_r_after_9", fifo_if.r, 0);
        feed(12'd10);
        fifo_if.rok = 1'b0;
        chk("halt_wc", wordCount, 3);
        chk("halt_ec", errCount, 1);
`else
        chk("resync_r_after_9", fifo_if.r, 1);
        feed(12'd10);
        fifo_if.rok = 1'b0;
        chk("resync_exp", expected, 12'd11);
        chk("resync_ec", errCount, 1);
        chk("resync_fail", fail, 1);
`endif

        // Reset mid-stream with rok held high, then a fresh unrelated sequence.
        do_reset();
        feed(12'h040);
        feed(12'h041);
        feed(12'h042);
        fifo_if.rd = 12'h043;
        do_reset();
        feed(12'h123);
        feed(12'h124);
        fifo_if.rok = 1'b0;
        chk("post_reset_ec", errCount, 0);
        chk("post_reset_fail", fail, 0);
        chk("post_reset_exp", expected, 12'h125);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
